// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: states, opcodes, select encodings and control word for the multi-cycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_SLTI = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b11;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_SLT   = 2'b10;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b00;

    localparam logic [1:0] ALUB_REG = 2'b00;
    localparam logic [1:0] ALUB_ONE = 2'b01;
    localparam logic [1:0] ALUB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic state_t dispatch(input logic [3:0] op);
        case (op)
            OP_LW, OP_SW:     return S_MEM_ADDR;
            OP_R:             return S_R_EXEC;
            OP_ADDI, OP_SLTI: return S_I_EXEC;
            OP_BEQ:           return S_BRANCH;
            OP_J:             return S_JUMP;
            OP_HALT:          return S_HALT;
            default:          return S_FETCH;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return dispatch(op) != S_FETCH;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: pure state -> control word decode (Moore outputs before strobe gating)
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   slti,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = ALUB_ONE;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_OP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = slti ? ALU_OP_SLT : ALU_OP_ADD;
            end
            S_I_WB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM with retired-instruction counter.
// Define MIPS_MEM_WAIT_EN to add the mem_ready port and stall memory states until it is high.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             zero,
`ifdef MIPS_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t     state, next;
    logic [3:0] op_q;
    logic       ready, retire;
    ctrl_t      ctrl;

`ifdef MIPS_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    // zero is consumed by the datapath together with pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:    next = ready ? S_DECODE : S_FETCH;
            S_DECODE:   next = dispatch(opcode);
            S_MEM_ADDR: next = op_q == OP_SW ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next = ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   next = ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   next = S_R_WB;
            S_I_EXEC:   next = S_I_WB;
            S_HALT:     next = S_HALT;
            default:    next = S_FETCH;
        endcase
    end

    // FETCH re-entries from FETCH (stall) or DECODE (illegal) retire nothing
    assign retire = next == S_FETCH && state != S_FETCH && state != S_DECODE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            op_q       <= '0;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            state      <= next;
            op_q       <= state == S_DECODE ? opcode : op_q;
            retired    <= retire ? retired + 1'b1 : retired;
            illegal_op <= state == S_DECODE && !is_legal(opcode);
        end
    end

    mc_ctrl_decode u_decode (
        .state (state),
        .slti  (op_q == OP_SLTI),
        .ctrl  (ctrl)
    );

    logic fetch_ok;
    assign fetch_ok = state != S_FETCH || ready;

    assign pc_write      = ctrl.pc_write & fetch_ok & ~reset;
    assign ir_write      = ctrl.ir_write & fetch_ok & ~reset;
    assign pc_write_cond = ctrl.pc_write_cond & ~reset;
    assign mem_read      = ctrl.mem_read & ~reset;
    assign mem_write     = ctrl.mem_write & ~reset;
    assign reg_write     = ctrl.reg_write & ~reset;
    assign pc_src        = ctrl.pc_src;
    assign i_or_d        = ctrl.i_or_d;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign halted        = state == S_HALT;

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: directed and random checks of mc_main_control against an instruction-step model
module tb_mc_main_control;

`ifdef MIPS_MEM_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [3:0]  opcode = 4'b0;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted, illegal_op;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic [15:0] retired;

    mc_main_control #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
`ifdef MIPS_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .halted(halted), .illegal_op(illegal_op), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, pwc; logic [1:0] pcs; logic iod, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, aop; logic hlt;
    } w_t;

    // model: step 0 = fetch, 1 = decode, 2.. = opcode-specific; instruction ends after len(op) steps
    int          m_step = 0;
    logic [3:0]  m_op = 4'b0;
    logic [15:0] m_ret = '0;
    logic        m_ill = 1'b0;
    int          n_checks = 0, n_err = 0;

    function automatic int len(input logic [3:0] op);
        case (op)
            4'b0100: return 5;
            4'b0110, 4'b0010: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b0010, 4'b1111};
    endfunction

    function automatic w_t expect_w(input logic rst, input logic rdy);
        w_t e = '0;
        if (m_step == 0) begin
            e.mrd = 1; e.asb = 2'b01; e.aop = 2'b11;
            e.pcw = !WAIT || rdy; e.irw = !WAIT || rdy;
        end else if (m_step == 1) begin
            e.asb = 2'b10; e.aop = 2'b11;
        end else if (m_step == 2) begin
            case (m_op)
                4'b0100, 4'b0101, 4'b0111: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; end
                4'b1000: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b10; end
                4'b0000: e.asa = 1;
                4'b0110: begin e.asa = 1; e.aop = 2'b01; e.pwc = 1; e.pcs = 2'b01; end
                4'b0010: begin e.pcw = 1; e.pcs = 2'b10; end
                default: e.hlt = 1;
            endcase
        end else if (m_step == 3) begin
            case (m_op)
                4'b0100: begin e.mrd = 1; e.iod = 1; end
                4'b0101: begin e.mwr = 1; e.iod = 1; end
                4'b0000: begin e.rw = 1; e.rdst = 1; end
                default: e.rw = 1;
            endcase
        end else begin
            e.rw = 1; e.m2r = 1;
        end
        if (rst) begin
            e.pcw = 0; e.pwc = 0; e.mrd = 0; e.mwr = 0; e.irw = 0; e.rw = 0;
        end
        return e;
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] op, input logic rdy);
        logic r = !WAIT || rdy;
        if (rst) begin
            m_step = 0; m_ret = '0; m_ill = 0;
            return;
        end
        m_ill = 0;
        if (m_step == 0) begin
            if (r) m_step = 1;
        end else if (m_step == 1) begin
            if (!legal(op)) begin m_step = 0; m_ill = 1; end
            else begin m_op = op; m_step = 2; end
        end else if (m_op == 4'b1111) begin
        end else if (m_step == 3 && (m_op == 4'b0100 || m_op == 4'b0101) && !r) begin
        end else if (m_step == len(m_op) - 1) begin
            m_step = 0; m_ret = m_ret + 16'd1;
        end else begin
            m_step = m_step + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic compare();
        w_t g;
        g = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted};
        chk($sformatf("ctrl step%0d op%b", m_step, m_op), 32'(g), 32'(expect_w(reset, mem_ready)));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        chk("retired", 32'(retired), 32'(m_ret));
    endtask

    // entered just after a falling edge; leaves just after the next falling edge
    task automatic tick(input logic r, input logic [3:0] op, input logic rdy, input logic z);
        reset = r; opcode = op; mem_ready = rdy; zero = z;
        #1 compare();
        @(posedge clk);
        model_edge(r, op, rdy);
        @(negedge clk);
    endtask

    logic [3:0] legal_ops [8] = '{4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b0010, 4'b1111};

    initial begin
        int hold = 0;
        @(negedge clk);
        tick(1, 4'b0000, 1, 0); tick(1, 4'b0000, 1, 0);
        chk("rst_retired", 32'(retired), 0); chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal_op), 0);
        // R-type
        tick(0, 4'b0000, 1, 0); tick(0, 4'b0000, 1, 0);
        chk("r_exec_aluop", 32'(alu_op), 0); chk("r_exec_srca", 32'(alu_src_a), 1);
        tick(0, 4'b0000, 1, 0);
        chk("r_wb_regwrite", 32'(reg_write), 1); chk("r_wb_regdst", 32'(reg_dst), 1);
        tick(0, 4'b0000, 1, 0);
        chk("r_retired", 32'(retired), 1); chk("r_model_ret", 32'(m_ret), 1);
        chk("r_back_fetch", 32'(ir_write), 1);
        // LW
        repeat (3) tick(0, 4'b0100, 1, 0);
        chk("lw_iord", 32'(i_or_d), 1); chk("lw_memread", 32'(mem_read), 1);
        tick(0, 4'b0100, 1, 0);
        chk("lw_memtoreg", 32'(mem_to_reg), 1); chk("lw_regwrite", 32'(reg_write), 1);
        tick(0, 4'b0100, 1, 0);
        chk("lw_retired", 32'(retired), 2);
        // BEQ taken and not taken
        for (int z = 1; z >= 0; z--) begin
            tick(0, 4'b0110, 1, 1'(z)); tick(0, 4'b0110, 1, 1'(z));
            chk("beq_aluop", 32'(alu_op), 1); chk("beq_pwc", 32'(pc_write_cond), 1);
            tick(0, 4'b0110, 1, 1'(z));
            chk("beq_fetch", 32'(ir_write), 1);
        end
        chk("beq_retired", 32'(retired), 4);
        // illegal, then HALT
        tick(0, 4'b1011, 1, 0); tick(0, 4'b1011, 1, 0);
        chk("ill_pulse", 32'(illegal_op), 1); chk("ill_retired", 32'(retired), 4);
        chk("ill_fetch", 32'(mem_read), 1); chk("ill_model", 32'(m_ill), 1);
        tick(0, 4'b1111, 1, 0); tick(0, 4'b1111, 1, 0);
        chk("ill_cleared", 32'(illegal_op), 0); chk("halt_on", 32'(halted), 1);
        repeat (20) tick(0, 4'b1111, 1, 0);
        chk("halt_held", 32'(halted), 1); chk("halt_retired", 32'(retired), 4);
        tick(1, 4'b0000, 1, 0);
        chk("halt_reset_ret", 32'(retired), 0); chk("halt_reset_hlt", 32'(halted), 0);
        // reset while in MEM_WR
        tick(0, 4'b0101, 1, 0); tick(0, 4'b0101, 1, 0); tick(0, 4'b0101, 1, 0);
        chk("sw_memwrite", 32'(mem_write), 1);
        reset = 1; #1 chk("sw_reset_gate", 32'(mem_write), 0);
        tick(1, 4'b0101, 1, 0);
        chk("sw_reset_ret", 32'(retired), 0); chk("sw_reset_fetch", 32'(alu_src_b), 1);
`ifdef MIPS_MEM_WAIT_EN
        tick(0, 4'b0100, 1, 0); tick(0, 4'b0100, 1, 0); tick(0, 4'b0100, 1, 0);
        repeat (3) begin
            tick(0, 4'b0100, 0, 0);
            chk("wait_memread", 32'(mem_read), 1);
        end
        tick(0, 4'b0100, 1, 0); tick(0, 4'b0100, 1, 0);
        chk("wait_lw_retired", 32'(retired), 1);
`endif
        // random traffic with occasional resets; long halts get reset
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic [3:0] op;
            hold = (m_step == 2 && m_op == 4'b1111) ? hold + 1 : 0;
            r = ($urandom_range(0, 49) == 0) || hold > 12;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
            tick(r, op, 1'($urandom_range(0, 2) != 0), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
